// File: rtl/lane_xfer_tx_pkg.sv
// Shared vector-unit types for the inter-lane operand network: operand type,
// lane count, transfer entry layout and transmit FSM states.
package pkg_tpu;

    localparam int TPU_NUM_LANES = 16;
    localparam int TPU_DATA_W    = 32;

    typedef logic [TPU_DATA_W-1:0] data_t;

    typedef struct packed {
        data_t                    src1;
        data_t                    src2;
        data_t                    src3;
        logic [TPU_NUM_LANES-1:0] mask;
    } xfer_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } xfer_tx_st_t;

endpackage

// File: rtl/lane_xfer_fifo.sv
// DEPTH-entry synchronous FIFO of transfer entries; head is read combinationally.
// Push while full and pop while empty are ignored.
module lane_xfer_fifo
    import pkg_tpu::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  xfer_entry_t              i_din,
    output xfer_entry_t              o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    xfer_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/lane_xfer_tx.sv
// Per-lane transmit stage: buffers operand triples and publishes the head entry
// until every destination lane acks. Optional sticky overflow: LANE_XFER_TX_OVF_EN.
module lane_xfer_tx
    import pkg_tpu::*;
#(
    parameter int LANE_ID   = 0,
    parameter int NUM_LANES = TPU_NUM_LANES,
    parameter int DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Req,
    input  data_t                I_Src_Data1,
    input  data_t                I_Src_Data2,
    input  data_t                I_Src_Data3,
    input  logic [NUM_LANES-1:0] I_Dst_Mask,
    input  logic [NUM_LANES-1:0] I_Ack,
    output logic                 O_Full,
    output logic                 O_Empty,
    output logic                 O_Lane_Valid,
    output data_t                O_Lane_Data_Src1,
    output data_t                O_Lane_Data_Src2,
    output data_t                O_Lane_Data_Src3,
    output logic [NUM_LANES-1:0] O_Pending,
    output logic                 O_Ovf
);

    localparam int CW = $clog2(DEPTH) + 1;

    xfer_tx_st_t          r_state, w_state_nxt;
    logic                 r_valid;
    data_t                r_d1, r_d2, r_d3;
    logic [NUM_LANES-1:0] r_pending;

    logic [NUM_LANES-1:0] w_mask_eff;
    logic [NUM_LANES-1:0] w_pend_nxt;
    logic                 w_push_ok;
    logic                 w_load;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CW-1:0]        w_count;
    xfer_entry_t          w_din;
    xfer_entry_t          w_head;

    // A lane never sends to itself, so its own mask bit is dropped on entry.
    assign w_mask_eff = I_Dst_Mask & ~(NUM_LANES'(1) << LANE_ID);
    assign w_push_ok  = I_Req && !w_fifo_full && (w_mask_eff != '0);
    assign w_pend_nxt = r_pending & ~I_Ack;

    assign w_din.src1 = I_Src_Data1;
    assign w_din.src2 = I_Src_Data2;
    assign w_din.src3 = I_Src_Data3;
    assign w_din.mask = TPU_NUM_LANES'(w_mask_eff);

    lane_xfer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push_ok),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: if (!w_fifo_empty) w_state_nxt = LOAD;
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: if (w_pend_nxt == '0) begin
                w_pop       = 1'b1;
                w_state_nxt = (w_count > CW'(1) || w_push_ok) ? LOAD : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_pending <= '0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_d1      <= w_head.src1;
            r_d2      <= w_head.src2;
            r_d3      <= w_head.src3;
            r_pending <= NUM_LANES'(w_head.mask);
        end else if (w_pop) begin
            r_valid   <= 1'b0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_pending <= '0;
        end else if (r_state == WAIT) begin
            r_pending <= w_pend_nxt;
        end
    end

    assign O_Full           = w_fifo_full;
    assign O_Empty          = w_fifo_empty && (r_state == IDLE);
    assign O_Lane_Valid     = r_valid;
    assign O_Lane_Data_Src1 = r_d1;
    assign O_Lane_Data_Src2 = r_d2;
    assign O_Lane_Data_Src3 = r_d3;
    assign O_Pending        = r_pending;

`ifdef LANE_XFER_TX_OVF_EN
    logic r_ovf;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                r_ovf <= 1'b0;
        else if (I_Req && O_Full)  r_ovf <= 1'b1;
    end
    assign O_Ovf = r_ovf;
`else
    assign O_Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_lane_xfer_tx.sv
// Directed vector bench for lane_xfer_tx (LANE_ID=0, 16 lanes, DEPTH=4):
// table of per-cycle stimulus/expectations plus back-to-back and mid-transfer reset sequences.
module tb_lane_xfer_tx;
    import pkg_tpu::*;

`ifdef LANE_XFER_TX_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Req;
    data_t       I_Src_Data1, I_Src_Data2, I_Src_Data3;
    logic [15:0] I_Dst_Mask, I_Ack;
    logic        O_Full, O_Empty, O_Lane_Valid, O_Ovf;
    data_t       O_Lane_Data_Src1, O_Lane_Data_Src2, O_Lane_Data_Src3;
    logic [15:0] O_Pending;

    int nvec = 0;
    int nmis = 0;

    always #5 clock = ~clock;

    lane_xfer_tx #(.LANE_ID(0), .NUM_LANES(16), .DEPTH(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .I_Req            (I_Req),
        .I_Src_Data1      (I_Src_Data1),
        .I_Src_Data2      (I_Src_Data2),
        .I_Src_Data3      (I_Src_Data3),
        .I_Dst_Mask       (I_Dst_Mask),
        .I_Ack            (I_Ack),
        .O_Full           (O_Full),
        .O_Empty          (O_Empty),
        .O_Lane_Valid     (O_Lane_Valid),
        .O_Lane_Data_Src1 (O_Lane_Data_Src1),
        .O_Lane_Data_Src2 (O_Lane_Data_Src2),
        .O_Lane_Data_Src3 (O_Lane_Data_Src3),
        .O_Pending        (O_Pending),
        .O_Ovf            (O_Ovf)
    );

    typedef struct {
        logic        req;
        logic [31:0] s1, s2, s3;
        logic [15:0] mask, ack;
        logic        ev;
        logic [31:0] e1, e2, e3;
        logic [15:0] ep;
        logic        ef, ee, eo;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3, input logic [15:0] ep,
                              input logic ef, input logic ee, input logic eo);
        chk({tag, ".valid"},   32'(O_Lane_Valid),  32'(ev));
        chk({tag, ".d1"},      O_Lane_Data_Src1,   e1);
        chk({tag, ".d2"},      O_Lane_Data_Src2,   e2);
        chk({tag, ".d3"},      O_Lane_Data_Src3,   e3);
        chk({tag, ".pending"}, 32'(O_Pending),     32'(ep));
        chk({tag, ".full"},    32'(O_Full),        32'(ef));
        chk({tag, ".empty"},   32'(O_Empty),       32'(ee));
        chk({tag, ".ovf"},     32'(O_Ovf),         32'(eo));
    endtask

    task automatic addv(input logic req, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] s3, input logic [15:0] mask, input logic [15:0] ack,
                        input logic ev, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] e3, input logic [15:0] ep,
                        input logic ef, input logic ee, input logic eo);
        vec_t v;
        v.req = req; v.s1 = s1; v.s2 = s2; v.s3 = s3; v.mask = mask; v.ack = ack;
        v.ev = ev; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.ep = ep;
        v.ef = ef; v.ee = ee; v.eo = eo;
        vq.push_back(v);
    endtask

    task automatic drive(input logic req, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] s3, input logic [15:0] mask, input logic [15:0] ack);
        I_Req = req; I_Src_Data1 = s1; I_Src_Data2 = s2; I_Src_Data3 = s3;
        I_Dst_Mask = mask; I_Ack = ack;
    endtask

    initial begin
        // Each row: inputs held for one cycle, outputs checked 1 time unit after that edge.
        // Single transfer, mask 0x0006.
        addv(1, 'h11, 'h22, 'h33, 16'h0006, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 16'h0000,                   0, 0, 0, 0, 16'h0000, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 16'h0000,                   1, 'h11, 'h22, 'h33, 16'h0006, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 16'h0002,                   1, 'h11, 'h22, 'h33, 16'h0004, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 16'h0004,                   0, 0, 0, 0, 16'h0000, 0, 1, 0);
        // Self-only mask is a no-op; then self bit stripped and stray acks ignored.
        addv(1, 'h99, 'h98, 'h97, 16'h0001, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
        addv(0, 0, 0, 0, 0, 16'h0000,                   0, 0, 0, 0, 16'h0000, 0, 1, 0);
        addv(1, 'hAA, 'hBB, 'hCC, 16'h0003, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 16'h0000,                   0, 0, 0, 0, 16'h0000, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 16'h0000,                   1, 'hAA, 'hBB, 'hCC, 16'h0002, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 16'hFFFC,                   1, 'hAA, 'hBB, 'hCC, 16'h0002, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 16'h0002,                   0, 0, 0, 0, 16'h0000, 0, 1, 0);
        // Fill: five pushes, fifth dropped.
        addv(1, 'h41, 'h51, 'h61, 16'h0002, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        addv(1, 'h42, 'h52, 'h62, 16'h0002, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        addv(1, 'h43, 'h53, 'h63, 16'h0002, 16'h0000, 1, 'h41, 'h51, 'h61, 16'h0002, 0, 0, 0);
        addv(1, 'h44, 'h54, 'h64, 16'h0002, 16'h0000, 1, 'h41, 'h51, 'h61, 16'h0002, 1, 0, 0);
        addv(1, 'h45, 'h55, 'h65, 16'h0002, 16'h0000, 1, 'h41, 'h51, 'h61, 16'h0002, 1, 0, OVF);
        // Drain: exactly four entries, in order.
        addv(0, 0, 0, 0, 0, 16'h0002,                   0, 0, 0, 0, 16'h0000, 0, 0, OVF);
        addv(0, 0, 0, 0, 0, 16'h0000,                   1, 'h42, 'h52, 'h62, 16'h0002, 0, 0, OVF);
        addv(0, 0, 0, 0, 0, 16'h0002,                   0, 0, 0, 0, 16'h0000, 0, 0, OVF);
        addv(0, 0, 0, 0, 0, 16'h0000,                   1, 'h43, 'h53, 'h63, 16'h0002, 0, 0, OVF);
        addv(0, 0, 0, 0, 0, 16'h0002,                   0, 0, 0, 0, 16'h0000, 0, 0, OVF);
        addv(0, 0, 0, 0, 0, 16'h0000,                   1, 'h44, 'h54, 'h64, 16'h0002, 0, 0, OVF);
        addv(0, 0, 0, 0, 0, 16'h0002,                   0, 0, 0, 0, 16'h0000, 0, 1, OVF);
        addv(0, 0, 0, 0, 0, 16'h0000,                   0, 0, 0, 0, 16'h0000, 0, 1, OVF);
        addv(0, 0, 0, 0, 0, 16'h0000,                   0, 0, 0, 0, 16'h0000, 0, 1, OVF);

        // Reset then idle.
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1 check_outs("rst", 0, 0, 0, 0, 0, 0, 1, 0);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            chk($sformatf("idle%0d.valid", c), 32'(O_Lane_Valid), 32'd0);
            chk($sformatf("idle%0d.empty", c), 32'(O_Empty), 32'd1);
        end

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].req, vq[i].s1, vq[i].s2, vq[i].s3, vq[i].mask, vq[i].ack);
            @(posedge clock); #1;
            check_outs($sformatf("v%0d", i), vq[i].ev, vq[i].e1, vq[i].e2, vq[i].e3,
                       vq[i].ep, vq[i].ef, vq[i].ee, vq[i].eo);
        end

        // Back-to-back: three entries, each acked in its first valid cycle.
        begin
            logic        pat [8];
            logic [31:0] dat [8];
            pat = '{0, 0, 1, 0, 1, 0, 1, 0};
            dat = '{0, 0, 'h71, 0, 'h72, 0, 'h73, 0};
            for (int c = 0; c < 8; c++) begin
                drive(c < 3, 32'h71 + 32'(c), 32'h81 + 32'(c), 32'h91 + 32'(c), 16'h0004, 16'h0004);
                @(posedge clock); #1;
                if (c >= 2) begin
                    chk($sformatf("b2b%0d.valid", c), 32'(O_Lane_Valid), 32'(pat[c]));
                    chk($sformatf("b2b%0d.d1", c), O_Lane_Data_Src1, dat[c]);
                end
            end
            chk("b2b.empty", 32'(O_Empty), 32'd1);
        end

        // Mid-transfer reset: one published, two queued.
        for (int c = 0; c < 3; c++) begin
            drive(1, 32'hA1 + 32'(c), 32'hB1 + 32'(c), 32'hC1 + 32'(c), 16'h0002, 16'h0000);
            @(posedge clock); #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("mr.pre_valid", 32'(O_Lane_Valid), 32'd1);
        chk("mr.pre_d1", O_Lane_Data_Src1, 32'hA1);
        reset = 1'b0;
        #2 check_outs("mr.async", 0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            chk($sformatf("mr%0d.valid", c), 32'(O_Lane_Valid), 32'd0);
            chk($sformatf("mr%0d.empty", c), 32'(O_Empty), 32'd1);
            chk($sformatf("mr%0d.d1", c), O_Lane_Data_Src1, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
